// File: rtl/interconnect_pkg.sv
// Shared types and helpers for the master SPI memory path: FSM states,
// default field widths and the even-parity helper.
package interconnect_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} spi_state_e;

  // Even parity over up to 64 bits; callers zero-extend narrower vectors.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI serializer: counts CLK_DIV cycles per half,
// owns the SCLK phase and strobes the cycle before each SCLK edge.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic run,
  output logic half_done,
  output logic rise,
  output logic fall,
  output logic sclk
);
  logic [7:0] cnt;
  logic       phase;

  assign half_done = en && (cnt == 8'(CLK_DIV - 1));
  assign rise      = half_done && run && !phase;
  assign fall      = half_done && run && phase;
  assign sclk      = phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      if (!en || half_done) cnt <= '0;
      else                  cnt <= cnt + 8'd1;
      if (rise || fall)     phase <= !phase;
    end
  end
endmodule

// File: rtl/master_spi_serializer.sv
// Shifts {address,instr} out as one SPI mode-0 frame and captures the node's
// reply. Define SPI_PARITY_EN to append/check an even-parity bit.
module master_spi_serializer
  import interconnect_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] instr,
  input  logic              miso,
  output logic              ready,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err
);
  localparam int NBITS = ADDR_W + DATA_W;
`ifdef SPI_PARITY_EN
  localparam int FRAME = NBITS + 1;
`else
  localparam int FRAME = NBITS;
`endif
  localparam int BCW = $clog2(FRAME + 1);

  spi_state_e       state, nxt;
  logic             valid_q, accept, en, run, last_low;
  logic             half_done, rise, fall;
  logic [FRAME-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [BCW-1:0]   bit_cnt;

  assign accept   = valid && !valid_q && ready;
  assign ready    = (state == IDLE);
  assign cs_n     = !(state inside {SETUP, SHIFT, HOLD});
  assign rx_valid = (state == DONE);
  assign mosi     = tx_sr[FRAME-1];
  assign en       = !cs_n;
  // bit_cnt already points past the last bit during its low half; stop SCLK there
  assign last_low = (state == SHIFT) && !sclk && (bit_cnt == BCW'(FRAME));
  assign run      = (state == SETUP) || ((state == SHIFT) && !last_low);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk, .rst_n, .en, .run, .half_done, .rise, .fall, .sclk
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (accept)               nxt = SETUP;
      SETUP: if (half_done)            nxt = SHIFT;
      SHIFT: if (half_done && last_low) nxt = HOLD;
      HOLD:  if (half_done)            nxt = DONE;
      DONE:                            nxt = IDLE;
      default:                         nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
    end else begin
      valid_q <= valid;
      if (accept) begin
`ifdef SPI_PARITY_EN
        tx_sr <= {address, instr, even_parity(64'({address, instr}))};
`else
        tx_sr <= {address, instr};
`endif
        bit_cnt <= '0;
      end else if (fall) begin
        tx_sr   <= {tx_sr[FRAME-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
      // address-phase samples are dropped; only data bits enter rx_sr
      if (rise && (bit_cnt >= BCW'(ADDR_W)) && (bit_cnt < BCW'(NBITS)))
        rx_sr <= {rx_sr[DATA_W-2:0], miso};
      if (state == HOLD && half_done)
        rx_data <= rx_sr;
    end
  end

`ifdef SPI_PARITY_EN
  logic rx_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_par     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (rise && (bit_cnt == BCW'(NBITS))) rx_par <= miso;
      if (state == HOLD && half_done)
        parity_err <= rx_par ^ even_parity(64'(rx_sr));
    end
  end
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_master_spi_serializer.sv
// Self-checking bench: frame-level timing model plus a simple SPI node model.
module tb_master_spi_serializer;
`ifdef SPI_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int D  = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int F  = AW + DW + PAR;
  localparam int L  = (2 + 2 * F) * D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          miso = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] instr = '0;
  logic          ready, sclk, mosi, cs_n, rx_valid, parity_err;
  logic [DW-1:0] rx_data;

  always #5 clk = ~clk;

  master_spi_serializer #(.CLK_DIV(D), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .address(address), .instr(instr),
    .miso(miso), .ready(ready), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // frame-level model
  bit          m_busy = 0, m_vq = 0, m_perr = 0, m_flip = 0;
  int          m_t = 0;
  logic [63:0] m_tx = '0;
  logic [31:0] m_reply = '0, m_rx = '0;

  // node and monitor
  logic [31:0] node_reply = '0;
  bit          node_flip = 0;
  int          nk = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  logic [63:0] cap = '0;
  int          frames = 0, pulses = 0, last_cs_low = 0, cs_low = 0, rises = 0;
  logic [31:0] last_data = '0;
  logic        last_perr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock: observe at the falling edge, check against the model, advance
  // the model with the inputs about to be sampled, then return just after
  // the next rising edge so the caller can drive new inputs.
  task automatic tick();
    logic [63:0] nf;
    int          idx;
    bit          was_idle;
    logic        e_cs, e_sclk, e_mosi, e_rdy, e_rxv;
    @(negedge clk);
    if (prev_cs && !cs_n) begin frames++; cap = '0; cs_low = 0; rises = 0; nk = 0; end
    if (!prev_cs && cs_n) last_cs_low = cs_low;
    if (!cs_n) cs_low++;
    if (!prev_sclk && sclk) begin cap = {cap[62:0], mosi}; rises++; end
    if (prev_sclk && !sclk && !cs_n) nk++;
    if (rx_valid) begin pulses++; last_data = rx_data; last_perr = parity_err; end
    prev_cs = cs_n;
    prev_sclk = sclk;

    nf = {24'h0, 8'hA5, node_reply};
    if (PAR == 1) nf = {nf[62:0], (^node_reply) ^ node_flip};
    miso = (!cs_n && nk < F) ? nf[F-1-nk] : 1'b0;

    if (!rst_n) begin
      m_busy = 0; m_t = 0; m_vq = 0; m_rx = '0; m_perr = 0;
    end
    if (m_busy) begin
      e_cs   = (m_t >= L);
      e_sclk = (m_t >= D) && (m_t < L - D) && (((m_t - D) % (2 * D)) < D);
      idx    = m_t / (2 * D);
      e_mosi = (idx < F) ? m_tx[F-1-idx] : 1'b0;
      e_rdy  = 1'b0;
      e_rxv  = (m_t == L);
    end else begin
      e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_rdy = 1'b1; e_rxv = 1'b0;
    end
    chk("cs_n", 64'(cs_n), 64'(e_cs));
    chk("sclk", 64'(sclk), 64'(e_sclk));
    chk("mosi", 64'(mosi), 64'(e_mosi));
    chk("ready", 64'(ready), 64'(e_rdy));
    chk("rx_valid", 64'(rx_valid), 64'(e_rxv));
    chk("rx_data", 64'(rx_data), 64'(m_rx));
    chk("parity_err", 64'(parity_err), 64'(m_perr));

    if (rst_n) begin
      was_idle = !m_busy;
      if (m_busy) begin
        m_t++;
        if (m_t == L) begin m_rx = m_reply; m_perr = m_flip; end
        if (m_t > L) m_busy = 0;
      end
      if (was_idle && valid && !m_vq) begin
        m_busy  = 1;
        m_t     = 0;
        m_tx    = {24'h0, address, instr};
        if (PAR == 1) m_tx = {m_tx[62:0], ^{address, instr}};
        m_reply = node_reply;
        m_flip  = (PAR == 1) ? node_flip : 1'b0;
      end
      m_vq = valid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_pulse(input int budget);
    int p0;
    int k;
    p0 = pulses;
    k = 0;
    while (pulses == p0 && k < budget) begin tick(); k++; end
    chk("rx_valid_timeout", 64'(pulses != p0), 64'd1);
  endtask

  task automatic send(input logic [7:0] a, input logic [31:0] d);
    address = a;
    instr = d;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_cap;
    int f0, p0;

    // reset and idle
    ticks(3);
    rst_n = 1'b1;
    ticks(20);
    chk("idle_no_frames", 64'(frames), 64'd0);
    chk("idle_ready", 64'(ready), 64'd1);

    // basic frame
    node_reply = 32'd10000;
    send(8'h05, 32'd50000);
    wait_pulse(400);
    exp_cap = 64'h05_0000C350;
    if (PAR == 1) exp_cap = exp_cap << 1;
    chk("basic_mosi_bits", cap, exp_cap);
    chk("basic_cs_low", 64'(last_cs_low), (PAR == 1) ? 64'd168 : 64'd164);
    chk("basic_rx_data", 64'(last_data), 64'd10000);
    ticks(5);
    chk("basic_single_pulse", 64'(pulses), 64'd1);

    // level-held valid
    f0 = frames; p0 = pulses;
    node_reply = 32'hDEAD_BEEF;
    address = 8'h3C; instr = 32'h1234_5678; valid = 1'b1;
    ticks(600);
    valid = 1'b0;
    tick();
    chk("level_one_frame", 64'(frames), 64'(f0 + 1));
    chk("level_one_pulse", 64'(pulses), 64'(p0 + 1));
    chk("level_rx_data", 64'(last_data), 64'h0000_0000_DEAD_BEEF);

    // back-to-back: next edge one cycle after rx_valid
    node_reply = 32'h0BAD_F00D;
    send(8'h11, 32'hA5A5_0001);
    wait_pulse(400);
    f0 = frames;
    node_reply = 32'h1357_9BDF;
    send(8'h22, 32'hFFFF_FFFF);
    chk("b2b_accept_cs", 64'(cs_n), 64'd0);
    chk("b2b_accept_ready", 64'(ready), 64'd0);
    ticks(100);
    chk("b2b_frame_started", 64'(frames), 64'(f0 + 1));
    chk("b2b_rx_held", 64'(rx_data), 64'h0BAD_F00D);
    wait_pulse(400);
    chk("b2b_data_ones", (cap >> PAR) & 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    chk("b2b_rx_data", 64'(last_data), 64'h1357_9BDF);

    // busy drop then reset abort
    tick();
    f0 = frames; p0 = pulses;
    node_reply = 32'h2468_ACE0;
    send(8'h44, 32'h0F0F_F0F0);
    ticks(20);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int k = 0; k < 100 && rises < 10; k++) tick();
    chk("abort_reached_10th", 64'(rises), 64'd10);
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 64'(cs_n), 64'd1);
    chk("abort_sclk", 64'(sclk), 64'd0);
    chk("abort_ready", 64'(ready), 64'd1);
    ticks(3);
    rst_n = 1'b1;
    ticks(400);
    chk("abort_no_pulse", 64'(pulses), 64'(p0));
    chk("busy_edge_dropped", 64'(frames), 64'(f0 + 1));

`ifdef SPI_PARITY_EN
    // parity slot: flipped node parity raises parity_err with rx_valid
    node_reply = 32'h8000_0001;
    node_flip = 1;
    send(8'h01, 32'h0000_0001);
    wait_pulse(400);
    exp_cap = 64'h01_0000_0001 << 1;
    chk("par_mosi_bits", cap, exp_cap);
    chk("par_tx_bit", 64'(cap[0]), 64'd0);
    chk("par_err_set", 64'(last_perr), 64'd1);
    chk("par_cs_low", 64'(last_cs_low), 64'd168);
    tick();
    node_flip = 0;
    send(8'h01, 32'h0000_0003);
    ticks(50);
    chk("par_err_held", 64'(parity_err), 64'd1);
    wait_pulse(400);
    chk("par_err_clear", 64'(last_perr), 64'd0);
    chk("par_rx_data", 64'(last_data), 64'h8000_0001);
`endif

    ticks(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/master_spi_serializer.md
# master_spi_serializer

Downstream stage of the master SPI memory. Takes the latched 32-bit instruction and its 8-bit target address, and shifts them out to the addressed node as one SPI mode-0 frame (MSB first). It captures the node's 32-bit reply on `miso` during the data phase. It presents the reply with a one-cycle valid pulse for the interconnect's response path.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period; legal range 1–255.
- `ADDR_W`, 8: address field width.
- `DATA_W`, 32: instruction/reply width.
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid` in 1: driven by the upstream `check`, level-held.
- `address` in ADDR_W: target node address; sampled at accept.
- `instr` in DATA_W: driven by the upstream `out_instr`; sampled at accept.
- `miso` in 1: serial data from the node.
- `ready` out 1: high in IDLE only.
- `sclk` out 1: SPI clock, idles low.
- `mosi` out 1: serial data to the node.
- `cs_n` out 1: chip select, active low.
- `rx_data` out DATA_W: last captured reply; holds its value until the next frame completes.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `parity_err` out 1: see Configuration.

## Operation
- Reset values: `ready`=1, `sclk`=0, `mosi`=0, `cs_n`=1, `rx_data`=0, `rx_valid`=0, `parity_err`=0.
- Frame: ADDR_W address bits, then DATA_W instruction bits, both MSB first. NBITS = ADDR_W+DATA_W (40 by default).
- Accept condition:
  - A register `valid_q` tracks `valid`.
  - A frame starts when `valid && !valid_q && ready`.
  - A level held high across frames launches only one frame.
  - A rising edge that arrives while busy is dropped, not queued.
- At accept, `{address,instr}` loads into a shift register and the bit counter is cleared.
- State IDLE: `cs_n`=1, `sclk`=0. On accept, go to SETUP.
- State SETUP: lasts CLK_DIV cycles. `cs_n`=0, `sclk`=0, `mosi`=frame MSB. Then go to SHIFT.
- State SHIFT: NBITS SCLK periods, each CLK_DIV cycles high then CLK_DIV cycles low.
  - `mosi` changes only at the falling `sclk` transition.
  - For bit index ≥ ADDR_W, `miso` is sampled into the rx shift register at each rising transition.
  - After the last low half, go to HOLD.
- State HOLD: lasts CLK_DIV cycles. `cs_n`=0, `sclk`=0. Then go to DONE.
- State DONE: lasts 1 cycle. `cs_n`=1, `rx_data` updates, `rx_valid`=1. Then go to IDLE.
- Bits captured during the address phase are discarded.
- Reset mid-frame: all outputs return to their reset values immediately (`cs_n` high, `sclk` low). No `rx_valid` is produced.

## Timing
- Accept at rising edge N: `ready` falls and `cs_n` falls, both visible after edge N.
- `cs_n` stays low for exactly (2 + 2·NBITS)·CLK_DIV cycles. With defaults (CLK_DIV=4, 40 bits) that is 328 cycles.
- `rx_valid` is high for the first cycle that `cs_n` is high again.
- `ready` returns high in the following cycle.
- Accept-to-`rx_valid` latency: (2 + 2·NBITS)·CLK_DIV + 1 cycles.
- The earliest next accept is 1 cycle after `rx_valid`.
- The half-period counter runs 0..CLK_DIV−1 and wraps. The bit counter is sized by $clog2(NBITS+1).

## Configuration
- `SPI_PARITY_EN` defined:
  - An even-parity bit over `{address,instr}` is appended as frame bit NBITS, making the frame NBITS+1 bits.
  - The node returns a parity bit over its reply in the same slot; it is sampled in that slot.
  - `parity_err` updates with `rx_data` and is 1 on mismatch. It holds its value until the next DONE.
  - `cs_n` low time becomes (2 + 2·(NBITS+1))·CLK_DIV cycles.
- `SPI_PARITY_EN` undefined: the frame is NBITS bits, `parity_err` is tied 0, and no parity logic is generated.

## Structure
- Shared package `interconnect_pkg`:
  - state enum IDLE/SETUP/SHIFT/HOLD/DONE
  - default ADDR_W/DATA_W constants
  - even-parity function
- One natural sub-module, `spi_clk_gen`:
  - half-period counter with enable
  - emits one-cycle `rise`/`fall` strobes and `half_done`
  - the FSM consumes the strobes

## Test plan
- Reset and idle: hold `rst_n`=0 for 3 cycles, then release with `valid`=0. Required: all outputs at reset values for 20 cycles; `cs_n` never falls.
- Basic frame (CLK_DIV=2): pulse `valid` with `address`=8'h05, `instr`=32'd50000; model `miso` replies 32'd10000. Required:
  - `mosi` bits sampled at rising `sclk` equal 40'h05_0000C350
  - `cs_n` low for 164 cycles
  - `rx_valid` single pulse with `rx_data`=32'd10000
- Level-held `valid`: hold `valid`=1 for 600 cycles. Required: exactly one frame and one `rx_valid` pulse.
- Back-to-back frames: send the next rising edge 1 cycle after `rx_valid` with `instr`=32'hFFFF_FFFF. Required:
  - accepted
  - second frame's `mosi` data bits are all 1
  - first frame's `rx_data` is held until the second frame's DONE
- Busy drop and reset abort:
  - Raise a second `valid` edge mid-SHIFT. Required: ignored.
  - Then assert `rst_n`=0 at the 10th `sclk` period. Required: `cs_n`=1 and `sclk`=0 immediately, and no `rx_valid`.
- With `SPI_PARITY_EN` defined:
  - Frame `{8'h01,32'h1}` has a parity bit of 0.
  - A node reply with a flipped parity bit gives `parity_err`=1 together with `rx_valid`.
  - `cs_n` low time is 168 cycles.
